// File: rtl/formula_nested_sqrt_pipe_pkg.sv
// Shared types, latency helpers and the digit-by-digit isqrt step used by the
// nested-root formula pipe.
package formula_nested_sqrt_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned ROOT_W = WORD_W / 2;

  typedef logic [WORD_W-1:0] word_t;

  typedef struct packed {
    word_t             x;
    logic [WORD_W+1:0] rem;
    logic [ROOT_W-1:0] root;
  } isqrt_st_t;

  function automatic int unsigned lat(input int unsigned n, input int unsigned s);
    return n * (s + 1);
  endfunction

  function automatic int unsigned op_delay(input int unsigned n, input int unsigned s,
                                           input int unsigned k);
    return (n - 1 - k) * (s + 1) - 1;
  endfunction

  function automatic int unsigned iters_per_stage(input int unsigned s);
    return (ROOT_W + s - 1) / s;
  endfunction

  // Consumes the top two bits of x per iteration, growing root by one bit.
  function automatic isqrt_st_t isqrt_steps(input isqrt_st_t st_in, input int unsigned n_iter);
    isqrt_st_t         st;
    logic [WORD_W+1:0] trial;
    st    = st_in;
    trial = '0;
    for (int unsigned i = 0; i < ROOT_W; i++) begin
      if (i < n_iter) begin
        st.rem = {st.rem[WORD_W-1:0], st.x[WORD_W-1 -: 2]};
        st.x   = {st.x[WORD_W-3:0], 2'b00};
        trial  = {{(WORD_W-ROOT_W){1'b0}}, st.root, 2'b01};
        if (st.rem >= trial) begin
          st.rem  = st.rem - trial;
          st.root = {st.root[ROOT_W-2:0], 1'b1};
        end else begin
          st.root = {st.root[ROOT_W-2:0], 1'b0};
        end
      end
    end
    return st;
  endfunction

endpackage

// File: rtl/formula_nested_sqrt_pipe_if.sv
// Operand/result bus of the nested-root formula pipe.
interface formula_nested_sqrt_pipe_if
  import formula_nested_sqrt_pkg::*;
#(
  parameter int unsigned N_LEVELS     = 3,
  parameter int unsigned ISQRT_STAGES = 4
);
  localparam int unsigned LAT   = lat(N_LEVELS, ISQRT_STAGES);
  localparam int unsigned CNT_W = $clog2(LAT + 1);

  logic                       arg_vld;
  word_t [N_LEVELS-1:0]       args;
  logic                       res_vld;
  word_t                      res;
  logic                       res_ovf;
  logic [CNT_W-1:0]           in_flight;

  modport master (output arg_vld, args, input res_vld, res, res_ovf, in_flight);
  modport slave  (input arg_vld, args, output res_vld, res, res_ovf, in_flight);
endinterface

// File: rtl/formula_nested_sqrt_pipe_level.sv
// One non-leaf level: add register, isqrt and overflow sideband.
// FORMULA_NESTED_SQRT_SAT_EN selects a saturating add instead of wrapping.
module nested_sqrt_level
  import formula_nested_sqrt_pkg::*;
#(
  parameter int unsigned ISQRT_STAGES = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  word_t x,
  input  logic  y_in_vld,
  input  word_t y_in,
  input  logic  ovf_in,
  output logic  y_vld,
  output word_t y,
  output logic  ovf
);
  localparam int unsigned S = ISQRT_STAGES;

  logic            sum_vld_q, sum_vld_d;
  word_t           sum_q, sum_d;
  logic            sum_ovf_q, sum_ovf_d;
  logic [WORD_W:0] sum_full;

  always_comb begin
    sum_full  = {1'b0, x} + {1'b0, y_in};
    sum_vld_d = y_in_vld;
    sum_d     = sum_q;
    sum_ovf_d = sum_ovf_q;
    if (y_in_vld) begin
`ifdef FORMULA_NESTED_SQRT_SAT_EN
      sum_d = sum_full[WORD_W] ? '1 : sum_full[WORD_W-1:0];
`else
      sum_d = sum_full[WORD_W-1:0];
`endif
      sum_ovf_d = sum_full[WORD_W] | ovf_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_vld_q <= 1'b0;
      sum_q     <= '0;
      sum_ovf_q <= 1'b0;
    end else begin
      sum_vld_q <= sum_vld_d;
      sum_q     <= sum_d;
      sum_ovf_q <= sum_ovf_d;
    end
  end

  logic  rst;
  logic  sq_vld;
  word_t sq_y;
  assign rst = ~rst_n;

  isqrt #(.n_pipe_stages(S)) u_isqrt (
    .clk   (clk),
    .rst   (rst),
    .x_vld (sum_vld_q),
    .x     (sum_q),
    .y_vld (sq_vld),
    .y     (sq_y)
  );

  // isqrt carries no sideband, so the ovf bit rides a matching valid-gated line.
  logic [S-1:0] ovf_vld_q, ovf_vld_d, ovf_sr_q, ovf_sr_d;
  logic [S:0]   ovf_vchain, ovf_chain;

  assign ovf_vchain = {ovf_vld_q, sum_vld_q};
  assign ovf_chain  = {ovf_sr_q, sum_ovf_q};

  always_comb begin
    ovf_vld_d = ovf_vchain[S-1:0];
    ovf_sr_d  = ovf_sr_q;
    for (int unsigned i = 0; i < S; i++) begin
      if (ovf_vchain[i]) ovf_sr_d[i] = ovf_chain[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_vld_q <= '0;
      ovf_sr_q  <= '0;
    end else begin
      ovf_vld_q <= ovf_vld_d;
      ovf_sr_q  <= ovf_sr_d;
    end
  end

  assign y_vld = sq_vld & ovf_vchain[S];
  assign y     = sq_y;
  assign ovf   = ovf_chain[S];
endmodule

// File: rtl/isqrt.sv
// Pipelined 32-bit integer square root; fixed latency of n_pipe_stages cycles,
// iterations spread evenly across the stages.
module isqrt
  import formula_nested_sqrt_pkg::*;
#(
  parameter int unsigned n_pipe_stages = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  x_vld,
  input  word_t x,
  output logic  y_vld,
  output word_t y
);
  localparam int unsigned PER_STAGE = iters_per_stage(n_pipe_stages);

  logic      [n_pipe_stages:0] vchain;
  isqrt_st_t [n_pipe_stages:0] schain;

  assign vchain[0] = x_vld;
  assign schain[0] = '{x: x, rem: '0, root: '0};

  for (genvar j = 0; j < n_pipe_stages; j++) begin : g_stage
    localparam int unsigned LO   = j * PER_STAGE;
    localparam int unsigned N_IT = (LO >= ROOT_W) ? 0 :
                                   ((ROOT_W - LO < PER_STAGE) ? ROOT_W - LO : PER_STAGE);
    logic      vld_q, vld_d;
    isqrt_st_t st_q, st_d;

    always_comb begin
      vld_d = vchain[j];
      st_d  = st_q;
      if (vchain[j]) st_d = isqrt_steps(schain[j], N_IT);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= 1'b0;
        st_q  <= '0;
      end else begin
        vld_q <= vld_d;
        st_q  <= st_d;
      end
    end

    assign vchain[j+1] = vld_q;
    assign schain[j+1] = st_q;
  end

  assign y_vld = vchain[n_pipe_stages];
  assign y     = {{(WORD_W-ROOT_W){1'b0}}, schain[n_pipe_stages].root};

  logic unused_tail;
  assign unused_tail = ^{schain[n_pipe_stages].x, schain[n_pipe_stages].rem};
endmodule

// File: rtl/formula_nested_sqrt_pipe.sv
// Pipelined evaluator of isqrt(x0 + isqrt(x1 + ... isqrt(x[N-1]))), one
// transaction per clock. FORMULA_NESTED_SQRT_SAT_EN makes the adds saturate.
module formula_nested_sqrt_pipe
  import formula_nested_sqrt_pkg::*;
#(
  parameter int unsigned N_LEVELS     = 3,
  parameter int unsigned ISQRT_STAGES = 4
) (
  input logic                       clk,
  input logic                       rst_n,
  formula_nested_sqrt_pipe_if.slave bus
);
  localparam int unsigned LAT   = lat(N_LEVELS, ISQRT_STAGES);
  localparam int unsigned CNT_W = $clog2(LAT + 1);

  logic  [N_LEVELS-1:0] y_vld_l;
  logic  [N_LEVELS-1:0] ovf_l;
  word_t [N_LEVELS-1:0] y_l;

  logic leaf_rst;
  assign leaf_rst = ~rst_n;

  isqrt #(.n_pipe_stages(ISQRT_STAGES)) u_leaf (
    .clk   (clk),
    .rst   (leaf_rst),
    .x_vld (bus.arg_vld),
    .x     (bus.args[N_LEVELS-1]),
    .y_vld (y_vld_l[N_LEVELS-1]),
    .y     (y_l[N_LEVELS-1])
  );
  assign ovf_l[N_LEVELS-1] = 1'b0;

  for (genvar k = 0; k < N_LEVELS - 1; k++) begin : g_level
    // x[k] must reach the adder exactly when the deeper result does.
    localparam int unsigned D = op_delay(N_LEVELS, ISQRT_STAGES, k);

    logic  [D-1:0] dvld_q, dvld_d;
    word_t [D-1:0] dx_q, dx_d;
    logic  [D:0]   vchain;
    word_t [D:0]   xchain;

    assign vchain = {dvld_q, bus.arg_vld};
    assign xchain = {dx_q, bus.args[k]};

    always_comb begin
      dvld_d = vchain[D-1:0];
      dx_d   = dx_q;
      for (int unsigned i = 0; i < D; i++) begin
        if (vchain[i]) dx_d[i] = xchain[i];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dvld_q <= '0;
        dx_q   <= '0;
      end else begin
        dvld_q <= dvld_d;
        dx_q   <= dx_d;
      end
    end

    logic unused_vld_tail;
    assign unused_vld_tail = vchain[D];

    nested_sqrt_level #(.ISQRT_STAGES(ISQRT_STAGES)) u_level (
      .clk      (clk),
      .rst_n    (rst_n),
      .x        (xchain[D]),
      .y_in_vld (y_vld_l[k+1]),
      .y_in     (y_l[k+1]),
      .ovf_in   (ovf_l[k+1]),
      .y_vld    (y_vld_l[k]),
      .y        (y_l[k]),
      .ovf      (ovf_l[k])
    );
  end

  logic             res_vld_q, res_vld_d;
  word_t            res_q, res_d;
  logic             res_ovf_q, res_ovf_d;
  logic [CNT_W-1:0] in_flight_q, in_flight_d;

  always_comb begin
    res_vld_d = y_vld_l[0];
    res_d     = res_q;
    res_ovf_d = res_ovf_q;
    if (y_vld_l[0]) begin
      res_d     = y_l[0];
      res_ovf_d = ovf_l[0];
    end
    in_flight_d = in_flight_q;
    case ({bus.arg_vld, res_vld_q})
      2'b10:   in_flight_d = in_flight_q + CNT_W'(1);
      2'b01:   in_flight_d = in_flight_q - CNT_W'(1);
      default: in_flight_d = in_flight_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_vld_q   <= 1'b0;
      res_q       <= '0;
      res_ovf_q   <= 1'b0;
      in_flight_q <= '0;
    end else begin
      res_vld_q   <= res_vld_d;
      res_q       <= res_d;
      res_ovf_q   <= res_ovf_d;
      in_flight_q <= in_flight_d;
    end
  end

  assign bus.res_vld   = res_vld_q;
  assign bus.res       = res_q;
  assign bus.res_ovf   = res_ovf_q;
  assign bus.in_flight = in_flight_q;
endmodule

// File: tb/tb_formula_nested_sqrt_pipe.sv
// Scoreboard bench for formula_nested_sqrt_pipe (defaults plus N=1 and N=5 builds).
module tb_formula_nested_sqrt_pipe;
  import formula_nested_sqrt_pkg::*;

  localparam int unsigned LAT_M = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  formula_nested_sqrt_pipe_if #(.N_LEVELS(3), .ISQRT_STAGES(4)) bus_m ();
  formula_nested_sqrt_pipe_if #(.N_LEVELS(1), .ISQRT_STAGES(2)) bus_1 ();
  formula_nested_sqrt_pipe_if #(.N_LEVELS(5), .ISQRT_STAGES(3)) bus_5 ();

  formula_nested_sqrt_pipe #(.N_LEVELS(3), .ISQRT_STAGES(4)) dut_m (.clk(clk), .rst_n(rst_n), .bus(bus_m));
  formula_nested_sqrt_pipe #(.N_LEVELS(1), .ISQRT_STAGES(2)) dut_1 (.clk(clk), .rst_n(rst_n), .bus(bus_1));
  formula_nested_sqrt_pipe #(.N_LEVELS(5), .ISQRT_STAGES(3)) dut_5 (.clk(clk), .rst_n(rst_n), .bus(bus_5));

  typedef struct {
    word_t  res;
    logic   ovf;
    longint t;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  longint      cyc = 0;
  int unsigned max_if = 0;
  int unsigned res_seen = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic word_t ref_isqrt(input word_t v);
    longint unsigned r, t;
    r = 0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= {32'd0, v}) r = t;
    end
    return r[31:0];
  endfunction

  function automatic exp_t ref_eval(input word_t [7:0] xs, input int n);
    exp_t        e;
    logic [32:0] s;
    word_t       y;
    y     = ref_isqrt(xs[n-1]);
    e.ovf = 1'b0;
    for (int k = n - 2; k >= 0; k--) begin
      s = {1'b0, xs[k]} + {1'b0, y};
      if (s[32]) e.ovf = 1'b1;
`ifdef FORMULA_NESTED_SQRT_SAT_EN
      y = ref_isqrt(s[32] ? 32'hFFFF_FFFF : s[31:0]);
`else
      y = ref_isqrt(s[31:0]);
`endif
    end
    e.res = y;
    e.t   = 0;
    return e;
  endfunction

  // Monitor: every result must match the oldest pending expectation, LAT cycles on.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_m.in_flight > max_if) max_if = bus_m.in_flight;
      if (bus_m.res_vld) begin
        exp_t e;
        res_seen++;
        chk("unexpected_res_vld", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("res", bus_m.res, e.res);
          chk("res_ovf", bus_m.res_ovf, e.ovf);
          chk("latency", cyc - e.t, LAT_M);
        end
      end
    end
  end

  task automatic send_exp(input word_t a0, input word_t a1, input word_t a2,
                          input word_t r, input logic o);
    exp_t e;
    @(negedge clk);
    bus_m.arg_vld = 1'b1;
    bus_m.args[0] = a0;
    bus_m.args[1] = a1;
    bus_m.args[2] = a2;
    e.res = r;
    e.ovf = o;
    e.t   = cyc;
    sb.push_back(e);
  endtask

  task automatic send_rand();
    word_t [7:0] xs;
    exp_t        e;
    xs = '0;
    for (int i = 0; i < 3; i++)
      xs[i] = ($urandom_range(0, 3) == 0) ? word_t'($urandom_range(0, 300)) : word_t'($urandom);
    e = ref_eval(xs, 3);
    send_exp(xs[0], xs[1], xs[2], e.res, e.ovf);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus_m.arg_vld = 1'b0;
    end
  endtask

  initial begin
    bit     got;
    longint t0, dl;
    rst_n = 1'b0;
    bus_m.arg_vld = 1'b0; bus_m.args = '0;
    bus_1.arg_vld = 1'b0; bus_1.args = '0;
    bus_5.arg_vld = 1'b0; bus_5.args = '0;
    repeat (3) @(negedge clk);
    chk("rst_res_vld", bus_m.res_vld, 0);
    chk("rst_res", bus_m.res, 0);
    chk("rst_res_ovf", bus_m.res_ovf, 0);
    chk("rst_in_flight", bus_m.in_flight, 0);
    rst_n = 1'b1;
    idle(2);

    // single transaction and in_flight profile
    send_exp(32'd6, 32'd5, 32'd16, 32'd3, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      bus_m.arg_vld = 1'b0;
      chk("in_flight_single", bus_m.in_flight, (i <= 15) ? 1 : 0);
    end

    // back-to-back random stream, then a bubble pattern
    for (int i = 0; i < 20; i++) send_rand();
    send_rand(); idle(1); send_rand(); send_rand(); idle(1);
    idle(LAT_M + 5);
    chk("stream_drain", sb.size(), 0);
    chk("in_flight_peak", max_if, LAT_M);

    // overflow flanked by non-overflowing transactions
    send_exp(32'd6, 32'd5, 32'd16, 32'd3, 1'b0);
`ifdef FORMULA_NESTED_SQRT_SAT_EN
    send_exp(32'hFFFF_FFFF, 32'd1, 32'd0, 32'd65535, 1'b1);
`else
    send_exp(32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b1);
`endif
    send_exp(32'd1, 32'd3, 32'd0, 32'd1, 1'b0);
    idle(LAT_M + 5);
    chk("ovf_drain", sb.size(), 0);

    // asynchronous reset with transactions in flight
    for (int i = 0; i < 5; i++) send_rand();
    @(negedge clk);
    bus_m.arg_vld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_res_vld", bus_m.res_vld, 0);
    chk("midrst_res", bus_m.res, 0);
    chk("midrst_res_ovf", bus_m.res_ovf, 0);
    chk("midrst_in_flight", bus_m.in_flight, 0);
    sb.delete();
    res_seen = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(20);
    chk("stale_after_reset", res_seen, 0);
    send_exp(32'd6, 32'd5, 32'd16, 32'd3, 1'b0);
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      @(negedge clk);
      bus_m.arg_vld = 1'b0;
    end
    chk("post_reset_result_timeout", sb.size(), 0);

    // N_LEVELS=1, ISQRT_STAGES=2
    @(negedge clk);
    bus_1.arg_vld = 1'b1;
    bus_1.args[0] = 32'd100;
    t0 = cyc; got = 0; dl = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      bus_1.arg_vld = 1'b0;
      if (bus_1.res_vld) begin
        got = 1;
        dl  = cyc - t0;
        chk("n1_res", bus_1.res, 10);
        chk("n1_res_ovf", bus_1.res_ovf, 0);
      end
    end
    chk("n1_seen", got, 1);
    chk("n1_latency", dl, 3);

    // N_LEVELS=5, ISQRT_STAGES=3
    @(negedge clk);
    bus_5.arg_vld = 1'b1;
    bus_5.args    = '0;
    bus_5.args[4] = 32'd256;
    t0 = cyc; got = 0; dl = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      bus_5.arg_vld = 1'b0;
      if (bus_5.res_vld) begin
        got = 1;
        dl  = cyc - t0;
        chk("n5_res", bus_5.res, 1);
        chk("n5_res_ovf", bus_5.res_ovf, 0);
      end
    end
    chk("n5_seen", got, 1);
    chk("n5_latency", dl, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
